// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the control unit and a 4-byte-wide big-endian data memory.
// Latency accept->resp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: one request in flight; req_ready low until the response is taken by resp_ready.
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), asynchronous active-low reset
//   i_req_valid / o_req_ready       CU request handshake; i_req_we, i_req_size,
//                                   i_req_unsigned, i_req_addr, i_req_wdata carry the request
//   o_resp_valid / i_resp_ready     CU response handshake; o_resp_rdata, o_resp_err
//   o_mem_addr, o_mem_wdata,        memory side: window base address, write word,
//   o_mem_we, i_mem_rdata           write enable, combinational read data at o_mem_addr
module lsu_mem_ctrl #(
  parameter int DEPTH = 24,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic [DW-1:0] o_resp_rdata,
  output logic          o_resp_err,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  // Highest legal window base: a 4-byte access from here ends on the last byte.
  localparam logic [AW-1:0] LP_WMAX  = AW'(DEPTH - 4);

  state_t        r_state;
  state_t        w_next;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_off;
  logic [DW-1:0] r_resp_rdata;
  logic          r_resp_err;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic [2:0]    w_nbytes;
  logic [AW:0]   w_end;
  logic          w_err;
  logic [AW-1:0] w_base;
  logic [1:0]    w_off;
  logic          w_accept;
  logic [4:0]    w_sh;
  logic [DW-1:0] w_shifted;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_ins;
  logic [DW-1:0] w_merged;
  logic [DW-1:0] w_load;
  logic          w_sign;

  // ---------------- request decode (IDLE) ----------------
  always_comb begin
    w_nbytes = 3'd4;
    case (i_req_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // One extra bit so addr+N cannot wrap past the memory size.
  assign w_end    = {1'b0, i_req_addr} + (AW+1)'(w_nbytes);
  assign w_err    = (i_req_size == 2'b11) || (w_end > LP_DEPTH);
  assign w_base   = (i_req_addr > LP_WMAX) ? LP_WMAX : i_req_addr;
  // addr - base is always 0..3, so the low two bits of the difference suffice.
  assign w_off    = i_req_addr[1:0] - w_base[1:0];
  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  // ---------------- read-word processing (RD) ----------------
  // Shifting left by the offset puts byte o of the window in bits [31:24].
  assign w_sh      = {r_off, 3'b000};
  assign w_shifted = i_mem_rdata << w_sh;

  always_comb begin
    w_mask = '1;
    w_ins  = r_wdata;
    case (r_size)
      2'b00: begin
        w_mask = 32'hFF00_0000 >> w_sh;
        w_ins  = {r_wdata[7:0], 24'h0} >> w_sh;
      end
      2'b01: begin
        w_mask = 32'hFFFF_0000 >> w_sh;
        w_ins  = {r_wdata[15:0], 16'h0} >> w_sh;
      end
      default: begin
        w_mask = '1;
        w_ins  = r_wdata;
      end
    endcase
  end

  assign w_merged = (i_mem_rdata & ~w_mask) | w_ins;

  always_comb begin
    w_sign = 1'b0;
    w_load = w_shifted;
    case (r_size)
      2'b00: begin
        w_sign = w_shifted[31] & ~r_uns;
        w_load = {{24{w_sign}}, w_shifted[31:24]};
      end
      2'b01: begin
        w_sign = w_shifted[31] & ~r_uns;
        w_load = {{16{w_sign}}, w_shifted[31:16]};
      end
      default: w_load = w_shifted;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_err)                               w_next = S_RESP;
          else if (i_req_we && i_req_size == 2'b10) w_next = S_WR;
          else                                     w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR: begin
        o_mem_we = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_wdata      <= '0;
      r_off        <= 2'b00;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      if (w_accept) begin
        r_we         <= i_req_we;
        r_size       <= i_req_size;
        r_uns        <= i_req_unsigned;
        r_wdata      <= i_req_wdata;
        r_off        <= w_off;
        r_resp_err   <= w_err;
        r_resp_rdata <= '0;
        // Memory outputs are only touched for requests that will reach memory.
        if (!w_err) begin
          r_mem_addr <= w_base;
          if (i_req_we && i_req_size == 2'b10) r_mem_wdata <= i_req_wdata;
        end
      end
      if (r_state == S_RD) begin
        if (r_we) r_mem_wdata  <= w_merged;
        else      r_resp_rdata <= w_load;
      end
    end
  end

  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised scoreboard bench for lsu_mem_ctrl with a byte-array reference memory.
// Driver issues one request at a time and queues expected responses and memory writes.
// A separate monitor pops and compares whenever the DUT writes memory or presents a response.
module tb_lsu_mem_ctrl;

  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;
  logic          o_resp_valid;
  logic          i_resp_ready;
  logic [DW-1:0] o_resp_rdata;
  logic          o_resp_err;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic [DW-1:0] mem_rdata;

  lsu_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  exp_t        eq[$];
  wr_t         wq[$];
  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  mem     [DEPTH];
  bit          mem_init = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  bit          stall_next = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void fail(string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // ---------------- memory model ----------------
  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 4; k++)
      if (int'(o_mem_addr) + k < DEPTH) mem_rdata[31-8*k -: 8] = mem[int'(o_mem_addr) + k];
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!mem_init) begin
        for (int i = 0; i < DEPTH; i++) mem[i] = ref_mem[i];
        mem_init = 1;
      end else if (o_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (int'(o_mem_addr) + k < DEPTH) mem[int'(o_mem_addr) + k] = o_mem_wdata[31-8*k -: 8];
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t        e;
    wr_t         w;
    bit          active;
    bit          prev_hs;
    int          stall_cnt;
    logic [31:0] held_rdata;
    logic        held_err;
    active = 0; prev_hs = 0; stall_cnt = 0;
    held_rdata = '0; held_err = 0;
    i_resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        active = 0; prev_hs = 0; stall_cnt = 0;
        i_resp_ready = 1'b1;
      end else begin
        if (prev_hs) begin
          chk("post_hs_resp_valid", 32'(o_resp_valid), 32'd0);
          chk("post_hs_req_ready", 32'(o_req_ready), 32'd1);
        end
        prev_hs = 0;
        if (o_mem_we) begin
          if (wq.size() == 0) fail("unexpected_mem_write");
          else begin
            w = wq.pop_front();
            chk("write_addr", 32'(o_mem_addr), 32'(w.addr));
            chk("write_data", o_mem_wdata, w.data);
          end
        end
        if (o_resp_valid) begin
          if (!active) begin
            active = 1;
            if (eq.size() == 0) fail("unexpected_response");
            else begin
              e = eq.pop_front();
              chk("resp_rdata", o_resp_rdata, e.rdata);
              chk("resp_err", 32'(o_resp_err), 32'(e.err));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              chk("writes_before_resp", 32'(wq.size()), 32'd0);
            end
            held_rdata = o_resp_rdata;
            held_err   = o_resp_err;
            if (stall_next) begin stall_cnt = 5; stall_next = 0; end
          end else begin
            chk("hold_rdata", o_resp_rdata, held_rdata);
            chk("hold_err", 32'(o_resp_err), 32'(held_err));
            chk("req_ready_in_resp", 32'(o_req_ready), 32'd0);
          end
          if (stall_cnt > 0) begin
            i_resp_ready = 1'b0;
            stall_cnt--;
          end else begin
            i_resp_ready = ($urandom_range(3, 0) != 0);
          end
          if (i_resp_ready) begin
            prev_hs = 1;
            active  = 0;
          end
        end else begin
          i_resp_ready = 1'($urandom_range(1, 0));
        end
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input int addr, input logic [31:0] wd, input bit model);
    int          t;
    int          n;
    int          wb;
    logic [31:0] v;
    exp_t        e;
    wr_t         w;
    t = 0;
    @(negedge clk);
    while (!o_req_ready && t < 100) begin @(negedge clk); t++; end
    if (!o_req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = AW'(addr);
    i_req_wdata    = wd;
    if (model) begin
      n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e.acc   = cyc;
      e.rdata = '0;
      e.err   = (size == 2'd3) || (addr + n > DEPTH);
      if (e.err) begin
        e.lat = 1;
      end else if (!we) begin
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[addr + k]);
        if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
        e.lat   = 2;
      end else begin
        for (int k = 0; k < n; k++) ref_mem[addr + k] = 8'(wd >> (8 * (n - 1 - k)));
        wb     = (addr < DEPTH - 4) ? addr : DEPTH - 4;
        w.addr = wb;
        w.data = {ref_mem[wb], ref_mem[wb+1], ref_mem[wb+2], ref_mem[wb+3]};
        wq.push_back(w);
        e.lat  = (n == 4) ? 2 : 3;
      end
      eq.push_back(e);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(eq.size() == 0 && o_req_ready) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail("idle_timeout");
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          t;
    logic [7:0]  saved;
    i_rst_n        = 1'b0;
    i_req_valid    = 1'b0;
    i_req_we       = 1'b0;
    i_req_size     = 2'b00;
    i_req_unsigned = 1'b0;
    i_req_addr     = '0;
    i_req_wdata    = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);

    #2;
    chk("rst_req_ready",  32'(o_req_ready),  32'd1);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_resp_err",   32'(o_resp_err),   32'd0);
    chk("rst_resp_rdata", o_resp_rdata,      32'd0);
    chk("rst_mem_we",     32'(o_mem_we),     32'd0);
    chk("rst_mem_addr",   32'(o_mem_addr),   32'd0);
    chk("rst_mem_wdata",  o_mem_wdata,       32'd0);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    mon_en  = 1;

    // Word store then word load at address 0.
    issue(1'b1, 2'd2, 1'b0, 0, 32'hDEAD_BEEF, 1);
    issue(1'b0, 2'd2, 1'b0, 0, 32'h0, 1);
    wait_idle();
    chk("dir_word_mem0", mem_word(0), 32'hDEAD_BEEF);

    // Sub-word store at the top of memory: window clamps to base 20.
    issue(1'b1, 2'd2, 1'b0, 20, 32'h1122_3344, 1);
    issue(1'b1, 2'd0, 1'b0, 23, 32'hFFFF_FFAB, 1);
    wait_idle();
    chk("dir_byte23_merge", mem_word(20), 32'h1122_33AB);

    // Half loads at 22, signed and unsigned.
    issue(1'b1, 2'd1, 1'b0, 22, 32'h0000_8001, 1);
    issue(1'b0, 2'd1, 1'b0, 22, 32'h0, 1);
    issue(1'b0, 2'd1, 1'b1, 22, 32'h0, 1);
    wait_idle();

    // Error paths: out-of-bounds word store and reserved size.
    issue(1'b1, 2'd2, 1'b0, 21, 32'hCAFE_F00D, 1);
    issue(1'b0, 2'd3, 1'b0, 0, 32'h0, 1);
    issue(1'b1, 2'd3, 1'b0, 4, 32'h1234_5678, 1);
    wait_idle();
    chk("dir_err_mem20", mem_word(20), 32'h1122_8001);

    // Response held off for 5 cycles.
    stall_next = 1;
    issue(1'b0, 2'd2, 1'b0, 0, 32'h0, 1);
    wait_idle();

    // Randomised traffic including out-of-range addresses and reserved sizes.
    for (int i = 0; i < 400; i++)
      issue(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
            int'($urandom_range(31, 0)), $urandom, 1);
    wait_idle();

    // Reset during the write cycle of a byte store.
    mon_en = 0;
    saved  = ref_mem[9];
    issue(1'b1, 2'd0, 1'b0, 9, {24'h0, ~saved}, 0);
    t = 0;
    while (!o_mem_we && t < 10) begin @(negedge clk); t++; end
    chk("rst_mid_reached_wr", 32'(o_mem_we), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we",     32'(o_mem_we),     32'd0);
    chk("rst_mid_req_ready",  32'(o_req_ready),  32'd1);
    chk("rst_mid_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_mid_resp_err",   32'(o_resp_err),   32'd0);
    chk("rst_mid_resp_rdata", o_resp_rdata,      32'd0);
    chk("rst_mid_mem_addr",   32'(o_mem_addr),   32'd0);
    chk("rst_mid_mem_wdata",  o_mem_wdata,       32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_byte_kept", 32'(mem[9]), 32'(saved));
    i_rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1;

    // Controller usable again after the reset.
    issue(1'b0, 2'd0, 1'b1, 9, 32'h0, 1);
    wait_idle();

    chk("final_resp_queue", 32'(eq.size()), 32'd0);
    chk("final_write_queue", 32'(wq.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk("final_mem_byte", 32'(mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
